// File: rtl/uart_tx_serializer_if.sv
// Host-side bus of the UART transmit serializer.
// Signals:
//   Select  [2:0]           baud select, latched when a frame is accepted
//   TxStart                 level-sensitive send request, acted on only while idle
//   TxData  [DATA_BITS-1:0] byte to send, latched when a frame is accepted
//   Tx                      serial line, idles high
//   Busy                    high from the accept cycle through the last stop bit
//   Done                    one-cycle pulse when a frame completes
// Modports: master = host/command logic, slave = serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [2:0]           Select;
    logic                 TxStart;
    logic [DATA_BITS-1:0] TxData;
    logic                 Tx;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Select, TxStart, TxData,
        input  Tx, Busy, Done
    );

    modport slave (
        input  Select, TxStart, TxData,
        output Tx, Busy, Done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity,
// STOP_BITS stop bits. Bit period comes from the same 3-bit Select baud
// table used by the receiver and is timed by an internal 15-bit counter.
// Ports:
//   Clk  system clock
//   Rst  synchronous, active-high reset
//   bus  uart_tx_serializer_if.slave (Select, TxStart, TxData in; Tx, Busy, Done out)
// Parameters: DATA_BITS (5..8), STOP_BITS (1 or 2), PARITY_ODD (0 even, 1 odd).
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input logic                 Clk,
    input logic                 Rst,
    uart_tx_serializer_if.slave bus
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t               state;
    logic [14:0]          cnt;      // counts 0..P-1 within a bit
    logic [14:0]          per_m1;   // P-1 for the latched Select
    logic [2:0]           bitcnt;   // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] sh;       // remaining data bits, LSB next
`ifdef UART_TX_PARITY_EN
    logic                 parbit;
`endif

    // Storing P-1 lets the end-of-bit test be a plain equality.
    function automatic logic [14:0] period_m1(input logic [2:0] s);
        case (s)
            3'b000:  return 15'd299;
            3'b001:  return 15'd20832;
            3'b010:  return 15'd10415;
            3'b011:  return 15'd5207;
            3'b100:  return 15'd2603;
            3'b101:  return 15'd199;
            3'b110:  return 15'd867;
            default: return 15'd99;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            per_m1   <= '0;
            bitcnt   <= '0;
            sh       <= '0;
`ifdef UART_TX_PARITY_EN
            parbit   <= 1'b0;
`endif
            bus.Tx   <= 1'b1;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            if (state == IDLE) begin
                if (bus.TxStart) begin
                    sh       <= bus.TxData;
                    per_m1   <= period_m1(bus.Select);
`ifdef UART_TX_PARITY_EN
                    parbit   <= (PARITY_ODD != 0) ? ~^bus.TxData : ^bus.TxData;
`endif
                    cnt      <= '0;
                    bitcnt   <= '0;
                    bus.Tx   <= 1'b0;
                    bus.Busy <= 1'b1;
                    state    <= START;
                end
            end else if (cnt != per_m1) begin
                cnt <= cnt + 15'd1;
            end else begin
                cnt <= '0;
                case (state)
                    START: begin
                        bus.Tx <= sh[0];
                        sh     <= sh >> 1;
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                    DATA: begin
                        if (bitcnt == LAST_DATA) begin
                            bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
                            bus.Tx <= parbit;
                            state  <= PARITY;
`else
                            bus.Tx <= 1'b1;
                            state  <= STOP;
`endif
                        end else begin
                            bus.Tx <= sh[0];
                            sh     <= sh >> 1;
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        bus.Tx <= 1'b1;
                        state  <= STOP;
                    end
`endif
                    STOP: begin
                        if (bitcnt == LAST_STOP) begin
                            bitcnt   <= '0;
                            bus.Busy <= 1'b0;
                            bus.Done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                    default: begin
                        bus.Tx   <= 1'b1;
                        bus.Busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (DATA_BITS=8,
// STOP_BITS=1, PARITY_ODD=0). Parity scenarios run only when
// UART_TX_PARITY_EN is defined for the build.
module tb_uart_tx_serializer;

    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 1 + DB + PAR + SB;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    uart_tx_serializer_if #(.DATA_BITS(DB)) bus ();

    uart_tx_serializer #(
        .DATA_BITS (DB),
        .STOP_BITS (SB),
        .PARITY_ODD(PODD)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (PAR == 1 && idx == DB + 1) return (PODD != 0) ? ~^d : ^d;
        return 1'b1;
    endfunction

    // Starts one frame from idle and checks every cycle of it, the Done
    // cycle and the cycle after. Optionally alters Select/TxData at
    // frame cycle chg_cycle to show they are not used mid-frame.
    task automatic run_frame(input logic [7:0] d, input logic [2:0] sel, input int p,
                             input string name, input int chg_cycle,
                             input logic [7:0] nd, input logic [2:0] nsel);
        @(negedge Clk);
        bus.TxData  = d;
        bus.Select  = sel;
        bus.TxStart = 1'b1;
        @(negedge Clk);
        bus.TxStart = 1'b0;
        for (int c = 1; c <= NBITS * p; c++) begin
            if (c == chg_cycle) begin
                bus.TxData = nd;
                bus.Select = nsel;
            end
            checks++;
            if (bus.Tx !== exp_bit(d, (c - 1) / p)) begin
                errors++;
                $display("FAIL %s_tx cycle %0d: got %b, expected %b", name, c, bus.Tx, exp_bit(d, (c - 1) / p));
            end
            checks++;
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy cycle %0d: got Busy=%b Done=%b, expected Busy=1 Done=0", name, c, bus.Busy, bus.Done);
            end
            @(negedge Clk);
        end
        checks++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_done cycle %0d: got Done=%b Busy=%b Tx=%b, expected 1 0 1", name, NBITS * p + 1, bus.Done, bus.Busy, bus.Tx);
        end
        @(negedge Clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got Done=%b Busy=%b, expected 0 0", name, bus.Done, bus.Busy);
        end
    endtask

    task automatic test_reset();
        Rst         = 1'b1;
        bus.TxStart = 1'b1;
        bus.TxData  = 8'hFF;
        bus.Select  = 3'b111;
        repeat (3) @(negedge Clk);
        checks++;
        if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got Tx=%b Busy=%b Done=%b, expected 1 0 0", bus.Tx, bus.Busy, bus.Done);
        end
        Rst         = 1'b0;
        bus.TxStart = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_frame: got Tx=%b Busy=%b, expected 1 0", bus.Tx, bus.Busy);
            end
        end
    endtask

    task automatic test_frame();
        run_frame(8'hA5, 3'b111, 100, "frame_a5", 0, 8'h00, 3'b000);
        run_frame(8'h3C, 3'b101, 200, "frame_3c", 0, 8'h00, 3'b000);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        run_frame(8'h07, 3'b101, 200, "parity_07", 0, 8'h00, 3'b000);
        run_frame(8'h03, 3'b101, 200, "parity_03", 0, 8'h00, 3'b000);
    endtask
`endif

    task automatic test_midframe_change();
        run_frame(8'hA5, 3'b111, 100, "chg_old", 450, 8'h5A, 3'b101);
        run_frame(8'h5A, 3'b101, 200, "chg_new", 0, 8'h00, 3'b000);
    endtask

    task automatic test_back_to_back();
        int flen;
        flen = NBITS * 100;
        @(negedge Clk);
        bus.TxData  = 8'hA5;
        bus.Select  = 3'b111;
        bus.TxStart = 1'b1;
        for (int t = 1; t <= 3 * (flen + 1); t++) begin
            int c;
            @(negedge Clk);
            c = ((t - 1) % (flen + 1)) + 1;
            if (t == 3 * (flen + 1)) bus.TxStart = 1'b0;
            if (c <= flen) begin
                checks++;
                if (bus.Tx !== exp_bit(8'hA5, (c - 1) / 100) || bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_frame t=%0d: got Tx=%b Busy=%b Done=%b, expected %b 1 0", t, bus.Tx, bus.Busy, bus.Done, exp_bit(8'hA5, (c - 1) / 100));
                end
            end else begin
                checks++;
                if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Tx !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap t=%0d: got Done=%b Busy=%b Tx=%b, expected 1 0 1", t, bus.Done, bus.Busy, bus.Tx);
                end
            end
        end
        @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stop: got Busy=%b Done=%b Tx=%b, expected 0 0 1", bus.Busy, bus.Done, bus.Tx);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge Clk);
        bus.TxData  = 8'hA5;
        bus.Select  = 3'b111;
        bus.TxStart = 1'b1;
        @(negedge Clk);
        bus.TxStart = 1'b0;
        for (int c = 1; c < 450; c++) begin
            checks++;
            if (bus.Tx !== exp_bit(8'hA5, (c - 1) / 100)) begin
                errors++;
                $display("FAIL rstmid_pre cycle %0d: got %b, expected %b", c, bus.Tx, exp_bit(8'hA5, (c - 1) / 100));
            end
            @(negedge Clk);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_reset: got Tx=%b Busy=%b Done=%b, expected 1 0 0", bus.Tx, bus.Busy, bus.Done);
        end
        Rst = 1'b0;
        repeat (300) begin
            @(negedge Clk);
            checks++;
            if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_idle: got Tx=%b Busy=%b Done=%b, expected 1 0 0", bus.Tx, bus.Busy, bus.Done);
            end
        end
        run_frame(8'hC3, 3'b111, 100, "rstmid_next", 0, 8'h00, 3'b000);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Rst         = 1'b1;
        bus.TxStart = 1'b0;
        bus.TxData  = '0;
        bus.Select  = '0;
        test_reset();
        test_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_midframe_change();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
